// File: rtl/serial_frame_rx.sv
// ============================================================================
// Module      : serial_frame_rx
// Description : Serial frame receiver. Hunts for a sync word, deserializes an
//               MSB-first payload, checks even parity, and presents the word on
//               a valid/ready port with overflow and parity-error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_rx #(
    parameter int                DATA_W       = 8,
    parameter int                SYNC_W       = 4,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sdi,
    input  logic              bit_en,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              frame_busy
);

    localparam int c_FILL_W = $clog2(SYNC_W + 1);
    localparam int c_CNT_W  = $clog2(DATA_W);

    localparam logic [c_FILL_W-1:0] c_FILL_MAX   = c_FILL_W'(SYNC_W);
    localparam logic [c_FILL_W-1:0] c_FILL_MATCH = c_FILL_W'(SYNC_W - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST   = c_CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SYNC_W-1:0]   r_window;
    logic [c_FILL_W-1:0] r_fill;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0]   r_shreg;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic                r_parity_err;
    logic                r_overflow;

    logic [SYNC_W-1:0]   w_sync_win;
    logic                w_match;
    logic                w_par_good;
    logic                w_par_step;
    logic                w_load;
    logic                w_drop_full;
    logic                w_perr;

    // The window must already hold SYNC_W-1 genuine bits so zeros left by
    // reset or a previous frame can never complete a match.
    assign w_sync_win  = {r_window[SYNC_W-2:0], sdi};
    assign w_match     = (r_fill >= c_FILL_MATCH) && (w_sync_win == SYNC_PATTERN);
    assign w_par_good  = ~((^r_shreg) ^ sdi);
    assign w_par_step  = (r_state == S_PARITY) && bit_en;
    assign w_load      = w_par_step && w_par_good && (!r_rx_valid || rx_ready);
    assign w_drop_full = w_par_step && w_par_good && r_rx_valid && !rx_ready;
    assign w_perr      = w_par_step && !w_par_good;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bit_en) begin
            case (r_state)
                S_HUNT:   if (w_match) w_state_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == c_CNT_LAST) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_HUNT;
                default:  w_state_nxt = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_window  <= '0;
            r_fill    <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
        end else if (bit_en) begin
            case (r_state)
                S_HUNT: begin
                    if (w_match) begin
                        r_window  <= '0;
                        r_fill    <= '0;
                        r_bit_cnt <= '0;
                    end else begin
                        r_window <= w_sync_win;
                        if (r_fill != c_FILL_MAX) r_fill <= r_fill + 1'b1;
                    end
                end
                S_DATA: begin
                    r_shreg   <= {r_shreg[DATA_W-2:0], sdi};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                default: begin
                    r_window <= '0;
                    r_fill   <= '0;
                end
            endcase
        end
    end

    // A new word loading in the same cycle as an accept keeps rx_valid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_parity_err <= w_perr;
            if (w_load) begin
                r_rx_data  <= r_shreg;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            if (w_drop_full) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign overflow   = r_overflow;
    assign frame_busy = (r_state == S_DATA) || (r_state == S_PARITY);

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
// ============================================================================
// Module      : tb_serial_frame_rx
// Description : Self-checking bench for serial_frame_rx against a bit-queue
//               reference model; directed scenarios followed by random frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_frame_rx;

    localparam int                DATA_W = 8;
    localparam int                SYNC_W = 4;
    localparam logic [SYNC_W-1:0] PAT    = 4'b1011;

    logic              clk;
    logic              reset;
    logic              sdi;
    logic              bit_en;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              parity_err;
    logic              overflow;
    logic              ovf_clr;
    logic              frame_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: bits seen while hunting, payload bits collected.
    int                m_hist[$];
    int                m_pay[$];
    bit                m_in_frame;
    logic              m_valid;
    logic              m_perr;
    logic              m_ovf;
    logic [DATA_W-1:0] m_data;

    serial_frame_rx #(
        .DATA_W      (DATA_W),
        .SYNC_W      (SYNC_W),
        .SYNC_PATTERN(PAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sdi       (sdi),
        .bit_en    (bit_en),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .parity_err(parity_err),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .frame_busy(frame_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_hist.delete();
        m_pay.delete();
        m_in_frame = 1'b0;
        m_valid    = 1'b0;
        m_perr     = 1'b0;
        m_ovf      = 1'b0;
        m_data     = '0;
    endfunction

    // Outcome of one clock edge given the inputs currently applied.
    function automatic void model_step(input logic s, input logic be, input logic rdy, input logic clr);
        bit                load = 0;
        bit                drop = 0;
        bit                perr = 0;
        bit                hit;
        int                ones;
        logic [DATA_W-1:0] word = '0;
        if (be) begin
            if (!m_in_frame) begin
                m_hist.push_back(int'(s));
                if (m_hist.size() > SYNC_W) void'(m_hist.pop_front());
                hit = (m_hist.size() == SYNC_W);
                for (int i = 0; i < SYNC_W; i++)
                    if (hit && m_hist[i] != int'(PAT[SYNC_W-1-i])) hit = 0;
                if (hit) begin
                    m_in_frame = 1'b1;
                    m_hist.delete();
                    m_pay.delete();
                end
            end else if (m_pay.size() < DATA_W) begin
                m_pay.push_back(int'(s));
            end else begin
                ones = int'(s);
                foreach (m_pay[i]) begin
                    ones += m_pay[i];
                    word = {word[DATA_W-2:0], m_pay[i][0]};
                end
                if (ones % 2 == 0) begin
                    if (!m_valid || rdy) load = 1;
                    else drop = 1;
                end else begin
                    perr = 1;
                end
                m_in_frame = 1'b0;
                m_hist.delete();
            end
        end
        m_perr = perr;
        if (load) begin
            m_valid = 1'b1;
            m_data  = word;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endfunction

    task automatic cycle(input logic s, input logic be, input logic rdy, input logic clr);
        @(negedge clk);
        sdi      = s;
        bit_en   = be;
        rx_ready = rdy;
        ovf_clr  = clr;
        model_step(s, be, rdy, clr);
        @(posedge clk);
        #1;
        check("rx_valid", 32'(rx_valid), 32'(m_valid));
        check("rx_data", 32'(rx_data), 32'(m_data));
        check("parity_err", 32'(parity_err), 32'(m_perr));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("frame_busy", 32'(frame_busy), 32'(m_in_frame));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        sdi      = 1'b0;
        bit_en   = 1'b0;
        rx_ready = 1'b0;
        ovf_clr  = 1'b0;
        model_reset();
        #1;
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_busy", 32'(frame_busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic par, input logic rdy);
        logic [SYNC_W+DATA_W:0] v;
        v = {PAT, d, par};
        for (int i = SYNC_W + DATA_W; i >= 0; i--) cycle(v[i], 1'b1, rdy, 1'b0);
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        logic [SYNC_W+DATA_W:0] v;
        logic [4:0] seq;
        reset    = 1'b1;
        sdi      = 1'b0;
        bit_en   = 1'b0;
        rx_ready = 1'b0;
        ovf_clr  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // 1: good frame with consumer ready
        send_frame(8'hA5, 1'b0, 1'b1);
        check("t1_valid", 32'(rx_valid), 32'd1);
        check("t1_data", 32'(rx_data), 32'hA5);
        check("t1_perr", 32'(parity_err), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_valid_drop", 32'(rx_valid), 32'd0);

        // 2: bad parity
        send_frame(8'hA5, 1'b1, 1'b1);
        check("t2_perr", 32'(parity_err), 32'd1);
        check("t2_valid", 32'(rx_valid), 32'd0);
        check("t2_busy", 32'(frame_busy), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("t2_perr_pulse", 32'(parity_err), 32'd0);

        // 3: overflow with consumer stalled, then clear
        send_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        check("t3_data_held", 32'(rx_data), 32'hA5);
        check("t3_ovf", 32'(overflow), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_ovf_clr", 32'(overflow), 32'd0);
        check("t3_valid_kept", 32'(rx_valid), 32'd1);

        // 4: reset mid-frame discards partial frame and pending word
        v = {PAT, 8'h5A, 1'b0};
        for (int i = SYNC_W + DATA_W; i > DATA_W - 3; i--) cycle(v[i], 1'b1, 1'b0, 1'b0);
        do_reset();
        send_frame(8'h3C, 1'b0, 1'b0);
        check("t4_data", 32'(rx_data), 32'h3C);
        check("t4_valid", 32'(rx_valid), 32'd1);
        check("t4_ovf", 32'(overflow), 32'd0);

        // 5: one bit every third clock
        do_reset();
        v = {PAT, 8'hFF, 1'b0};
        for (int i = SYNC_W + DATA_W; i >= 0; i--) begin
            cycle(1'($urandom), 1'b0, 1'b0, 1'b0);
            cycle(1'($urandom), 1'b0, 1'b0, 1'b0);
            cycle(v[i], 1'b1, 1'b0, 1'b0);
        end
        check("t5_data", 32'(rx_data), 32'hFF);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_idle_valid", 32'(rx_valid), 32'd1);

        // 6: no early match on cleared window; overlapping detection
        do_reset();
        seq = 5'b01011;
        for (int i = 3; i >= 0; i--) begin
            cycle(seq[i], 1'b1, 1'b1, 1'b0);
            check("t6_busy_a", 32'(frame_busy), (i == 0) ? 32'd1 : 32'd0);
        end
        do_reset();
        seq = 5'b11011;
        for (int i = 4; i >= 0; i--) begin
            cycle(seq[i], 1'b1, 1'b1, 1'b0);
            check("t6_busy_b", 32'(frame_busy), (i == 0) ? 32'd1 : 32'd0);
        end

        // Random frames with noise, gaps, back-pressure and clears
        do_reset();
        for (int f = 0; f < 60; f++) begin
            int nnoise;
            nnoise = int'($urandom_range(0, 4));
            d = DATA_W'($urandom);
            v = {PAT, d, (^d) ^ ($urandom_range(0, 9) < 2)};
            for (int n = 0; n < nnoise; n++)
                cycle(1'($urandom), 1'b1, 1'($urandom), ($urandom_range(0, 9) == 0));
            for (int i = SYNC_W + DATA_W; i >= 0; i--) begin
                if ($urandom_range(0, 3) == 0)
                    cycle(1'($urandom), 1'b0, 1'($urandom), ($urandom_range(0, 9) == 0));
                cycle(v[i], 1'b1, 1'($urandom), ($urandom_range(0, 9) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
